// File: rtl/np_mem_arbiter_pkg.sv
// Shared definitions for the np memory arbiter: default sizes and owner encoding.
package np_mem_arbiter_pkg;

   localparam int unsigned DEF_WIDTH    = 32;
   localparam int unsigned DEF_ADDRSIZE = 12;
   localparam int unsigned DEF_MAX_HOLD = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_P0   = 2'd1,
      OWN_P1   = 2'd2
   } owner_e;

endpackage

// File: rtl/np_arb_hold_cnt.sv
// Saturating consecutive-grant counter and round-robin pointer for the memory arbiter.
module np_arb_hold_cnt
   import np_mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
   localparam int unsigned HOLD_W  = $clog2(MAX_HOLD + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              gnt_any,
   input  logic              gnt_same,
   input  logic              gnt_port,
   output logic [HOLD_W-1:0] hold_cnt,
   output logic              rr_ptr
);

   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              rr_ptr_q, rr_ptr_d;

   always_comb begin
      hold_cnt_d = '0;
      rr_ptr_d   = rr_ptr_q;
      if (gnt_any) begin
         rr_ptr_d = ~gnt_port;
         if (!gnt_same) begin
            hold_cnt_d = HOLD_W'(1);
         end else if (hold_cnt_q == HOLD_W'(MAX_HOLD)) begin
            hold_cnt_d = hold_cnt_q;
         end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt_q <= '0;
         rr_ptr_q   <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign hold_cnt = hold_cnt_q;
   assign rr_ptr   = rr_ptr_q;

endmodule

// File: rtl/np_mem_arbiter.sv
// Two-master arbiter for the single-port np memory: hold-limited round-robin,
// combinational grant/memory drive, one-cycle read-valid pipeline.
module np_mem_arbiter
   import np_mem_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned ADDRSIZE = DEF_ADDRSIZE,
   parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req0,
   input  logic                wr0,
   input  logic [ADDRSIZE-1:0] addr0,
   input  logic [WIDTH-1:0]    wdata0,
   output logic                gnt0,
   output logic                rvalid0,
   input  logic                req1,
   input  logic                wr1,
   input  logic [ADDRSIZE-1:0] addr1,
   input  logic [WIDTH-1:0]    wdata1,
   output logic                gnt1,
   output logic                rvalid1,
   output logic [WIDTH-1:0]    rdata,
   output logic [ADDRSIZE-1:0] mem_addr,
   output logic                mem_wr,
   output logic [WIDTH-1:0]    mem_wdata,
   input  logic [WIDTH-1:0]    mem_rdata
);

   localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

   owner_e              owner_q, owner_d;
   logic [HOLD_W-1:0]   hold_cnt;
   logic                rr_ptr;
   logic                gnt0_c, gnt1_c, gnt_same_c;
   logic [ADDRSIZE-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
   logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;

   // Grant decision; requests are ignored while reset is high.
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (!reset) begin
         if (req0 && !req1) begin
            gnt0_c = 1'b1;
         end else if (req1 && !req0) begin
            gnt1_c = 1'b1;
         end else if (req0 && req1) begin
            case (owner_q)
               OWN_P0: begin
                  if (hold_cnt < HOLD_W'(MAX_HOLD)) gnt0_c = 1'b1;
                  else                              gnt1_c = 1'b1;
               end
               OWN_P1: begin
                  if (hold_cnt < HOLD_W'(MAX_HOLD)) gnt1_c = 1'b1;
                  else                              gnt0_c = 1'b1;
               end
               default: begin
                  if (rr_ptr) gnt1_c = 1'b1;
                  else        gnt0_c = 1'b1;
               end
            endcase
         end
      end
   end

   always_comb begin
      owner_d     = OWN_NONE;
      gnt_same_c  = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rvalid0_d   = gnt0_c & ~wr0;
      rvalid1_d   = gnt1_c & ~wr1;
      if (gnt0_c) begin
         owner_d     = OWN_P0;
         gnt_same_c  = (owner_q == OWN_P0);
         mem_addr_d  = addr0;
         mem_wdata_d = wdata0;
      end else if (gnt1_c) begin
         owner_d     = OWN_P1;
         gnt_same_c  = (owner_q == OWN_P1);
         mem_addr_d  = addr1;
         mem_wdata_d = wdata1;
      end
   end

   np_arb_hold_cnt #(
      .MAX_HOLD (MAX_HOLD)
   ) u_hold_cnt (
      .clk      (clk),
      .reset    (reset),
      .gnt_any  (gnt0_c | gnt1_c),
      .gnt_same (gnt_same_c),
      .gnt_port (gnt1_c),
      .hold_cnt (hold_cnt),
      .rr_ptr   (rr_ptr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q     <= OWN_NONE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
      end else begin
         owner_q     <= owner_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
      end
   end

   // Reset kills an in-flight read immediately, not one edge later.
   assign rvalid0   = rvalid0_q & ~reset;
   assign rvalid1   = rvalid1_q & ~reset;
   assign gnt0      = gnt0_c;
   assign gnt1      = gnt1_c;
   assign mem_wr    = (gnt0_c & wr0) | (gnt1_c & wr1);
   assign mem_addr  = reset ? '0 : mem_addr_d;
   assign mem_wdata = reset ? '0 : mem_wdata_d;
   assign rdata     = mem_rdata;

endmodule

// File: tb/tb_np_mem_arbiter.sv
// Bench for np_mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_np_mem_arbiter;
   import np_mem_arbiter_pkg::*;

   localparam int unsigned W  = 32;
   localparam int unsigned A  = 12;
   localparam int unsigned MH = 4;

   logic         clk, reset;
   logic         req0, wr0, req1, wr1;
   logic [A-1:0] addr0, addr1, mem_addr;
   logic [W-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
   logic         gnt0, gnt1, rvalid0, rvalid1, mem_wr;

   np_mem_arbiter #(.WIDTH(W), .ADDRSIZE(A), .MAX_HOLD(MH)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
      .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
      .rdata(rdata), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write-first synchronous memory
   logic [W-1:0] mem [int];
   always @(posedge clk) begin
      if (mem_wr) begin
         mem[int'(mem_addr)] = mem_wdata;
         mem_rdata <= mem_wdata;
      end else begin
         mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : '0;
      end
   end

   // Transaction-level model state
   logic [W-1:0] shadow [int];
   int           m_last;    // -1 = nobody granted last cycle
   int           m_streak;  // consecutive grants to m_last
   int           m_fav;     // port preferred on a fresh contention
   logic [A-1:0] m_addr;
   logic [W-1:0] m_wdata;
   bit           m_rv0, m_rv1;
   logic [W-1:0] m_rexp;

   int n_checks, n_fail;
   bit obs_gnt0, obs_gnt1, obs_rv0, obs_rv1, obs_wr;
   logic [W-1:0] obs_rdata;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_grant();
      if (reset) return -1;
      if (req0 && !req1) return 0;
      if (req1 && !req0) return 1;
      if (!req0 && !req1) return -1;
      if (m_last < 0) return m_fav;
      if (m_streak < int'(MH)) return m_last;
      return 1 - m_last;
   endfunction

   task automatic drive(input int p, input bit r, input bit w, input logic [A-1:0] a, input logic [W-1:0] d);
      if (p == 0) begin req0 = r; wr0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = r; wr1 = w; addr1 = a; wdata1 = d; end
   endtask

   // One clock: check outputs mid-cycle, then advance the model at the edge.
   task automatic step();
      int           g;
      bit           w;
      logic [A-1:0] a;
      logic [W-1:0] d;
      @(negedge clk);
      g = exp_grant();
      w = (g == 0) ? wr0 : wr1;
      a = (g == 0) ? addr0 : ((g == 1) ? addr1 : m_addr);
      d = (g == 0) ? wdata0 : ((g == 1) ? wdata1 : m_wdata);
      if (reset) begin a = '0; d = '0; end
      obs_gnt0 = gnt0; obs_gnt1 = gnt1; obs_rv0 = rvalid0; obs_rv1 = rvalid1;
      obs_rdata = rdata; obs_wr = mem_wr;
      check("gnt0", 64'(gnt0), 64'(g == 0));
      check("gnt1", 64'(gnt1), 64'(g == 1));
      check("mem_wr", 64'(mem_wr), 64'(g >= 0 && w));
      check("mem_addr", 64'(mem_addr), 64'(a));
      check("mem_wdata", 64'(mem_wdata), 64'(d));
      check("rvalid0", 64'(rvalid0), 64'(m_rv0 && !reset));
      check("rvalid1", 64'(rvalid1), 64'(m_rv1 && !reset));
      if ((m_rv0 || m_rv1) && !reset) check("rdata", 64'(rdata), 64'(m_rexp));
      @(posedge clk);
      m_rv0 = 0; m_rv1 = 0;
      if (reset) begin
         m_last = -1; m_streak = 0; m_fav = 0; m_addr = '0; m_wdata = '0;
      end else if (g < 0) begin
         m_last = -1; m_streak = 0;
      end else begin
         if (w) shadow[int'(a)] = d;
         else begin
            m_rexp = shadow.exists(int'(a)) ? shadow[int'(a)] : '0;
            if (g == 0) m_rv0 = 1; else m_rv1 = 1;
         end
         if (g == m_last) m_streak = (m_streak < int'(MH)) ? m_streak + 1 : m_streak;
         else             m_streak = 1;
         m_last = g; m_fav = 1 - g; m_addr = a; m_wdata = d;
      end
      #1;
   endtask

   task automatic rand_txn(input int p);
      logic [A-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? A'(12'hFFF) : A'($urandom_range(0, 7));
      drive(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom);
   endtask

   initial begin
      int  cnt;
      bit  got_p0;
      n_checks = 0; n_fail = 0;
      m_last = -1; m_streak = 0; m_fav = 0; m_addr = '0; m_wdata = '0;
      m_rv0 = 0; m_rv1 = 0; m_rexp = '0;
      reset = 1'b1;
      drive(0, 0, 0, '0, '0);
      drive(1, 0, 0, '0, '0);
      #1;

      // Requests are ignored during reset; grant in the first free cycle
      drive(0, 1, 0, A'(12'h010), '0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t1_rst_gnt0", 64'(obs_gnt0), 64'(0));
         check("t1_rst_wr", 64'(obs_wr), 64'(0));
      end
      reset = 1'b0;
      step();
      check("t1_first_gnt0", 64'(obs_gnt0), 64'(1));
      drive(0, 0, 0, '0, '0);
      step();

      // Write then read back on port 0
      drive(0, 1, 1, A'(12'h005), 32'hDEADBEEF);
      step();
      drive(0, 1, 0, A'(12'h005), '0);
      step();
      drive(0, 0, 0, '0, '0);
      step();
      check("t2_rvalid0", 64'(obs_rv0), 64'(1));
      check("t2_rdata", 64'(obs_rdata), 64'(32'hDEADBEEF));
      check("t2_rvalid1", 64'(obs_rv1), 64'(0));

      // Continuous contention from reset release: blocks of MAX_HOLD grants
      reset = 1'b1;
      step();
      drive(0, 1, 0, A'(12'h001), '0);
      drive(1, 1, 0, A'(12'h002), '0);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         check("t3_gnt0", 64'(obs_gnt0), 64'(((i / 4) % 2) == 0));
         check("t3_gnt1", 64'(obs_gnt1), 64'(((i / 4) % 2) == 1));
      end

      // Port 1 saturates its hold count alone, then port 0 arrives
      drive(0, 0, 0, '0, '0);
      drive(1, 0, 0, '0, '0);
      step();
      drive(1, 1, 0, A'(12'h003), '0);
      for (int i = 0; i < 6; i++) step();
      drive(0, 1, 0, A'(12'h004), '0);
      cnt = 0; got_p0 = 0;
      for (int i = 0; i < 8 && !got_p0; i++) begin
         step();
         if (obs_gnt1) cnt++;
         if (obs_gnt0) got_p0 = 1;
      end
      check("t4_p0_granted", 64'(got_p0), 64'(1));
      check("t4_p1_run_le_max", 64'(cnt <= int'(MH)), 64'(1));
      drive(0, 0, 0, '0, '0);
      drive(1, 0, 0, '0, '0);
      step();

      // Reset while a port 1 read is in flight
      drive(1, 1, 0, A'(12'hFFF), '0);
      step();
      check("t5_gnt1", 64'(obs_gnt1), 64'(1));
      drive(1, 0, 0, '0, '0);
      reset = 1'b1;
      step();
      check("t5_rvalid1", 64'(obs_rv1), 64'(0));
      check("t5_mem_wr", 64'(obs_wr), 64'(0));
      reset = 1'b0;
      step();
      check("t5_no_gnt", 64'(obs_gnt0 | obs_gnt1), 64'(0));

      // P0 write and P1 read of the same word, served back to back
      drive(0, 1, 1, A'(12'h7FF), 32'h1);
      drive(1, 1, 0, A'(12'h7FF), '0);
      step();
      check("t6_p0_first", 64'(obs_gnt0), 64'(1));
      drive(0, 0, 0, '0, '0);
      step();
      check("t6_p1_next", 64'(obs_gnt1), 64'(1));
      drive(1, 0, 0, '0, '0);
      step();
      check("t6_rvalid1", 64'(obs_rv1), 64'(1));
      check("t6_rdata", 64'(obs_rdata), 64'(32'h1));

      // Random traffic with occasional reset pulses
      rand_txn(0);
      rand_txn(1);
      for (int i = 0; i < 2000; i++) begin
         reset = ($urandom_range(0, 63) == 0);
         step();
         if (!req0 || obs_gnt0) rand_txn(0);
         if (!req1 || obs_gnt1) rand_txn(1);
      end
      reset = 1'b0;
      drive(0, 0, 0, '0, '0);
      drive(1, 0, 0, '0, '0);
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
